// File: rtl/blake2_pkg.sv
// Shared BLAKE2b constants, the h initialisation helper and the loader FSM state codes.
package blake2_pkg;

  localparam int unsigned W     = 64;
  localparam int unsigned BLK_W = 16;

  localparam logic [W-1:0] PARAM_BLOCK = 64'h0000_0000_0101_0000;

  // IV[0] in the lowest word.
  localparam logic [8*W-1:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFill   = 3'd1;
  localparam state_t StLaunch = 3'd2;
  localparam state_t StWait   = 3'd3;
  localparam state_t StDone   = 3'd4;

  function automatic logic [8*W-1:0] h_init(input logic [6:0] nn);
    logic [8*W-1:0] h;
    h = IV;
    h[W-1:0] = h[W-1:0] ^ PARAM_BLOCK ^ {{(W-7){1'b0}}, nn};
    return h;
  endfunction

endpackage

// File: rtl/blake2b_block_loader_if.sv
// Word stream, compression-core and digest signals of the block loader, seen from the loader.
interface blake2b_block_loader_if;

  logic                                        data_valid_i;
  logic                                        data_ready_o;
  logic [blake2_pkg::W-1:0]                    data_i;
  logic                                        data_last_i;
  logic [3:0]                                  data_bytes_i;
  logic [6:0]                                  cfg_nn_i;
  logic                                        cmp_valid_o;
  logic [blake2_pkg::BLK_W*blake2_pkg::W-1:0]  cmp_m_o;
  logic [8*blake2_pkg::W-1:0]                  cmp_h_o;
  logic [2*blake2_pkg::W-1:0]                  cmp_t_o;
  logic                                        cmp_f_o;
  logic                                        cmp_valid_i;
  logic [8*blake2_pkg::W-1:0]                  cmp_h_i;
  logic                                        digest_valid_o;
  logic [8*blake2_pkg::W-1:0]                  digest_o;
  logic                                        digest_ready_i;

  modport slave (
    input  data_valid_i, data_i, data_last_i, data_bytes_i, cfg_nn_i, cmp_valid_i, cmp_h_i,
           digest_ready_i,
    output data_ready_o, cmp_valid_o, cmp_m_o, cmp_h_o, cmp_t_o, cmp_f_o, digest_valid_o,
           digest_o
  );

  modport master (
    output data_valid_i, data_i, data_last_i, data_bytes_i, cfg_nn_i, cmp_valid_i, cmp_h_i,
           digest_ready_i,
    input  data_ready_o, cmp_valid_o, cmp_m_o, cmp_h_o, cmp_t_o, cmp_f_o, digest_valid_o,
           digest_o
  );

endinterface

// File: rtl/blake2b_byte_mask.sv
// Zeroes every byte at position >= i_count in a little-endian word.
module blake2b_byte_mask
  import blake2_pkg::*;
(
  input  logic [W-1:0] i_word,
  input  logic [3:0]   i_count,
  output logic [W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    for (int unsigned b = 0; b < W / 8; b++) begin
      if (b < 32'(i_count)) o_word[8*b +: 8] = i_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/blake2b_block_loader.sv
// Packs 64-bit words into zero-padded 16-word BLAKE2b blocks, launches the core per block and
// folds its h back. Define BLAKE2_CFG_NN_EN to take the digest length from cfg_nn_i.
module blake2b_block_loader
  import blake2_pkg::*;
(
  input logic                   clk,
  input logic                   nreset,
  blake2b_block_loader_if.slave bus
);

  state_t               r_state;
  logic                 r_alive;
  logic [3:0]           r_cnt;
  logic [2*W-1:0]       r_t;
  logic                 r_f;
  logic [BLK_W*W-1:0]   r_m;
  logic [8*W-1:0]       r_h;

  logic                 w_accept;
  logic                 w_end_blk;
  logic [3:0]           w_keep;
  logic [W-1:0]         w_word;
  logic [7:0]           w_blk_bytes;
  logic [2*W-1:0]       w_t_inc;
  logic [6:0]           w_nn;

`ifdef BLAKE2_CFG_NN_EN
  assign w_nn = bus.cfg_nn_i;
`else
  logic w_unused_nn;
  assign w_unused_nn = ^bus.cfg_nn_i;
  assign w_nn        = 7'd64;
`endif

  assign bus.data_ready_o   = r_alive & ((r_state == StIdle) | (r_state == StFill));
  assign bus.cmp_valid_o    = (r_state == StLaunch);
  assign bus.cmp_m_o        = r_m;
  assign bus.cmp_h_o        = r_h;
  assign bus.cmp_t_o        = r_t;
  assign bus.cmp_f_o        = r_f;
  assign bus.digest_valid_o = (r_state == StDone);
  assign bus.digest_o       = r_h;

  assign w_accept    = bus.data_ready_o & bus.data_valid_i;
  assign w_end_blk   = bus.data_last_i | (r_cnt == 4'd15);
  assign w_keep      = bus.data_last_i ? bus.data_bytes_i : 4'd8;
  // Bytes already in the block plus the valid bytes of the closing word.
  assign w_blk_bytes = {1'b0, r_cnt, 3'b000} + {4'd0, bus.data_bytes_i};
  assign w_t_inc     = bus.data_last_i ? {{(2*W-8){1'b0}}, w_blk_bytes}
                                       : {{(2*W-8){1'b0}}, 8'd128};

  blake2b_byte_mask u_byte_mask (
    .i_word  (bus.data_i),
    .i_count (w_keep),
    .o_word  (w_word)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= StIdle;
      r_alive <= 1'b0;
      r_cnt   <= '0;
      r_t     <= '0;
      r_f     <= 1'b0;
      r_m     <= '0;
      r_h     <= h_init(7'd64);
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        StIdle, StFill: begin
          if (w_accept) begin
            if (r_state == StIdle) r_h <= h_init(w_nn);
            r_m[r_cnt*W +: W] <= w_word;
            if (w_end_blk) begin
              r_cnt   <= '0;
              r_t     <= r_t + w_t_inc;
              r_f     <= bus.data_last_i;
              r_state <= StLaunch;
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_state <= StFill;
            end
          end
        end
        StLaunch: r_state <= StWait;
        StWait: begin
          // Clearing m here pre-pads the next block; unwritten words stay zero.
          if (bus.cmp_valid_i) begin
            r_h     <= bus.cmp_h_i;
            r_m     <= '0;
            r_state <= r_f ? StDone : StFill;
          end
        end
        StDone: begin
          if (bus.digest_ready_i) begin
            r_h     <= h_init(w_nn);
            r_t     <= '0;
            r_f     <= 1'b0;
            r_cnt   <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2b_block_loader.sv
// Self-checking bench: acts as the BLAKE2b core and compares launches and digests with a model.
module tb_blake2b_block_loader;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  blake2b_block_loader_if bus ();

  blake2b_block_loader dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    int len;
    int kind;      // 1 = "abc", 0 = random bytes
    int n_launch;
    int last_t;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned   msg_q[$];
  logic [1023:0]  exp_m[8];
  logic [127:0]   exp_t[8];
  logic           exp_f[8];
  logic [511:0]   exp_h[8];
  int             exp_n;
  logic [511:0]   exp_digest;
  int             launches;
  logic [127:0]   last_t_seen;
  int             core_lat = -1;
  bit             spur_en  = 1'b1;
  logic [63:0]    fv[16];
  logic [63:0]    fm[16];

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] iv_ref(int i);
    case (i)
      0: return 64'h6a09e667f3bcc908;
      1: return 64'hbb67ae8584caa73b;
      2: return 64'h3c6ef372fe94f82b;
      3: return 64'ha54ff53a5f1d36f1;
      4: return 64'h510e527fade682d1;
      5: return 64'h9b05688c2b3e6c1f;
      6: return 64'h1f83d9abfb41bd6b;
      default: return 64'h5be0cd19137e2179;
    endcase
  endfunction

  function automatic logic [63:0] sig_row(int r);
    case (r)
      0: return 64'h0123456789ABCDEF;
      1: return 64'hEA489FD61C02B753;
      2: return 64'hB8C052FDAE367194;
      3: return 64'h7931DCBE265A40F8;
      4: return 64'h905724AFE1BC683D;
      5: return 64'h2C6A0B834D75FE19;
      6: return 64'hC51FED4A0763928B;
      7: return 64'hDB7EC13950F4862A;
      8: return 64'h6FE9B308C2D714A5;
      default: return 64'hA2847615FB9E3CD0;
    endcase
  endfunction

  function automatic int sg(logic [63:0] row, int k);
    return int'(row[63-4*k -: 4]);
  endfunction

  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic void g_mix(int a, int b, int c, int d, logic [63:0] x, logic [63:0] y);
    fv[a] = fv[a] + fv[b] + x;  fv[d] = ror(fv[d] ^ fv[a], 32);
    fv[c] = fv[c] + fv[d];      fv[b] = ror(fv[b] ^ fv[c], 24);
    fv[a] = fv[a] + fv[b] + y;  fv[d] = ror(fv[d] ^ fv[a], 16);
    fv[c] = fv[c] + fv[d];      fv[b] = ror(fv[b] ^ fv[c], 63);
  endfunction

  // Reference BLAKE2b compression F.
  function automatic logic [511:0] blk_f(logic [511:0] h, logic [1023:0] m, logic [127:0] t,
                                         logic f);
    logic [63:0]  row;
    logic [511:0] r;
    for (int i = 0; i < 8; i++) begin
      fv[i]   = h[64*i +: 64];
      fv[i+8] = iv_ref(i);
    end
    for (int i = 0; i < 16; i++) fm[i] = m[64*i +: 64];
    fv[12] = fv[12] ^ t[63:0];
    fv[13] = fv[13] ^ t[127:64];
    if (f) fv[14] = ~fv[14];
    for (int rd = 0; rd < 12; rd++) begin
      row = sig_row(rd % 10);
      g_mix(0, 4,  8, 12, fm[sg(row, 0)],  fm[sg(row, 1)]);
      g_mix(1, 5,  9, 13, fm[sg(row, 2)],  fm[sg(row, 3)]);
      g_mix(2, 6, 10, 14, fm[sg(row, 4)],  fm[sg(row, 5)]);
      g_mix(3, 7, 11, 15, fm[sg(row, 6)],  fm[sg(row, 7)]);
      g_mix(0, 5, 10, 15, fm[sg(row, 8)],  fm[sg(row, 9)]);
      g_mix(1, 6, 11, 12, fm[sg(row, 10)], fm[sg(row, 11)]);
      g_mix(2, 7,  8, 13, fm[sg(row, 12)], fm[sg(row, 13)]);
      g_mix(3, 4,  9, 14, fm[sg(row, 14)], fm[sg(row, 15)]);
    end
    for (int i = 0; i < 8; i++) r[64*i +: 64] = h[64*i +: 64] ^ fv[i] ^ fv[i+8];
    return r;
  endfunction

  function automatic logic [511:0] h_init_ref(int nn);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = iv_ref(i);
    r[63:0] = r[63:0] ^ 64'h0101_0000 ^ 64'(nn);
    return r;
  endfunction

  // Message-level model: split msg_q into 128-byte blocks and chain F over them.
  function automatic void build_expect(int nn);
    int n, nblk, idx;
    logic [511:0] hcur;
    n     = msg_q.size();
    nblk  = (n == 0) ? 1 : (n + 127) / 128;
    hcur  = h_init_ref(nn);
    exp_n = nblk;
    for (int b = 0; b < nblk; b++) begin
      exp_m[b] = '0;
      for (int i = 0; i < 128; i++) begin
        idx = b * 128 + i;
        if (idx < n) exp_m[b][8*i +: 8] = msg_q[idx];
      end
      exp_f[b] = (b == nblk - 1);
      exp_t[b] = exp_f[b] ? 128'(n) : 128'(128 * (b + 1));
      exp_h[b] = hcur;
      hcur     = blk_f(hcur, exp_m[b], exp_t[b], exp_f[b]);
    end
    exp_digest = hcur;
  endfunction

  function automatic void check_launch();
    string p;
    p = $sformatf("launch%0d", launches);
    chk({p, " in range"}, 512'(launches < exp_n), 512'(1));
    if (launches < exp_n && launches < 8) begin
      chk({p, " t"},    512'(bus.cmp_t_o), 512'(exp_t[launches]));
      chk({p, " f"},    512'(bus.cmp_f_o), 512'(exp_f[launches]));
      chk({p, " m lo"}, bus.cmp_m_o[511:0],    exp_m[launches][511:0]);
      chk({p, " m hi"}, bus.cmp_m_o[1023:512], exp_m[launches][1023:512]);
      chk({p, " h"},    bus.cmp_h_o,           exp_h[launches]);
    end
    last_t_seen = bus.cmp_t_o;
    launches++;
  endfunction

  // Core stand-in: answers each launch after a variable delay, with stray pulses in between.
  initial begin : core_model
    logic [511:0] hn;
    int lat;
    bus.cmp_valid_i = 1'b0;
    bus.cmp_h_i     = '0;
    forever begin
      @(posedge clk); #1;
      bus.cmp_valid_i = 1'b0;
      bus.cmp_h_i     = {16{$urandom}};
      if (nreset === 1'b1 && bus.cmp_valid_o === 1'b1) begin
        check_launch();
        hn  = blk_f(bus.cmp_h_o, bus.cmp_m_o, bus.cmp_t_o, bus.cmp_f_o);
        lat = (core_lat < 0) ? int'($urandom_range(0, 4)) : core_lat;
        repeat (1 + lat) @(posedge clk);
        #1;
        bus.cmp_h_i     = hn;
        bus.cmp_valid_i = 1'b1;
      end else if (nreset === 1'b1 && spur_en && $urandom_range(0, 5) == 0) begin
        bus.cmp_valid_i = 1'b1;
      end
    end
  end

  task automatic send_word(logic [63:0] d, logic last, logic [3:0] nb, output bit ok);
    bit rdy;
    bus.data_valid_i = 1'b1;
    bus.data_i       = d;
    bus.data_last_i  = last;
    bus.data_bytes_i = nb;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      rdy = bus.data_ready_o;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
    bus.data_i       = {$urandom, $urandom};
  endtask

  // Sends msg_q as words (garbage in the unused tail bytes), stopping after stop_words.
  task automatic send_msg(int stop_words, output bit ok);
    int n, nw, nb;
    logic [63:0] w;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    ok = 1'b1;
    for (int k = 0; k < nw && k < stop_words && ok; k++) begin
      w  = {$urandom, $urandom};
      nb = (k == nw - 1) ? n - 8 * k : 8;
      for (int b = 0; b < 8; b++) if (8 * k + b < n) w[8*b +: 8] = msg_q[8*k + b];
      send_word(w, k == nw - 1, 4'(nb), ok);
    end
  endtask

  task automatic fill_msg(int len, int kind);
    msg_q.delete();
    if (kind == 1) begin
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
    end else begin
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic run_msg(string name, int len, int kind, int n_l, int last_t);
    bit ok;
    int c, nn, nn_eff;
    logic [511:0] rfc_abc, rfc_h;
    fill_msg(len, kind);
    nn = (kind == 1) ? 64 : int'($urandom_range(1, 64));
    bus.cfg_nn_i = 7'(nn);
`ifdef BLAKE2_CFG_NN_EN
    nn_eff = nn;
`else
    nn_eff = 64;
`endif
    build_expect(nn_eff);
    launches = 0;
    send_msg(1000, ok);
    chk({name, " word handshake"}, 512'(ok), 512'(1));
    c = 0;
    while (bus.digest_valid_o !== 1'b1 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, " digest_valid"}, 512'(bus.digest_valid_o), 512'(1));
    chk({name, " ready in DONE"}, 512'(bus.data_ready_o), 512'(0));
    chk({name, " digest"}, bus.digest_o, exp_digest);
    chk({name, " launch count"}, 512'(launches), 512'(n_l));
    chk({name, " final t"}, 512'(last_t_seen), 512'(last_t));
    if (kind == 1) begin
      rfc_abc = 512'hBA80A53F981C4D0D6A2797B69F12F6E94C212F14685AC4B74B12BB6FDBFFA2D17D87C5392AAB792DC252D5DE4533CC9518D38AA8DBF1925AB92386EDD4009923;
      for (int i = 0; i < 64; i++) rfc_h[8*i +: 8] = rfc_abc[511 - 8*i -: 8];
      chk({name, " RFC 7693 digest"}, bus.digest_o, rfc_h);
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    chk({name, " digest held"}, 512'(bus.digest_valid_o), 512'(1));
    bus.digest_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready_i = 1'b0;
    chk({name, " back to idle"}, 512'(bus.data_ready_o), 512'(1));
  endtask

  task automatic check_reset_state(string name);
    chk({name, " ready"},        512'(bus.data_ready_o),   512'(0));
    chk({name, " cmp_valid"},    512'(bus.cmp_valid_o),    512'(0));
    chk({name, " digest_valid"}, 512'(bus.digest_valid_o), 512'(0));
    chk({name, " t"},            512'(bus.cmp_t_o),        512'(0));
    chk({name, " m lo"},         bus.cmp_m_o[511:0],       512'(0));
    chk({name, " m hi"},         bus.cmp_m_o[1023:512],    512'(0));
    chk({name, " h"},            bus.cmp_h_o,              h_init_ref(64));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[9];
    bit ok;
    int c, stall_bad, len;
    logic [1023:0] m0;
    logic [127:0]  t0;
    logic [511:0]  h0;

    vecs = '{
      '{3,   1, 1, 3},    // "abc"
      '{0,   0, 1, 0},    // empty message
      '{128, 0, 1, 128},  // exact block, no extra
      '{129, 0, 2, 129},
      '{1,   0, 1, 1},
      '{17,  0, 1, 17},
      '{255, 0, 2, 255},
      '{256, 0, 2, 256},
      '{300, 0, 3, 300}
    };

    nreset             = 1'b0;
    bus.data_valid_i   = 1'b1;
    bus.data_i         = '0;
    bus.data_last_i    = 1'b0;
    bus.data_bytes_i   = 4'd8;
    bus.cfg_nn_i       = 7'd64;
    bus.digest_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    bus.data_valid_i = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("ready after release", 512'(bus.data_ready_o), 512'(1));

    for (int i = 0; i < 9; i++)
      run_msg($sformatf("vec%0d", i), vecs[i].len, vecs[i].kind, vecs[i].n_launch,
              vecs[i].last_t);

    for (int i = 0; i < 4; i++) begin
      len = int'($urandom_range(0, 400));
      run_msg($sformatf("rand%0d", i), len, 0, (len == 0) ? 1 : (len + 127) / 128, len);
    end

    // Slow core: the pending word must stay untaken and launch outputs frozen during WAIT.
    core_lat = 15;
    spur_en  = 1'b0;
    fork
      run_msg("stall", 129, 0, 2, 129);
      begin
        c = 0;
        while (bus.cmp_valid_o !== 1'b1 && c < 2000) begin
          @(posedge clk); #1;
          c++;
        end
        chk("stall launch seen", 512'(bus.cmp_valid_o), 512'(1));
        m0 = bus.cmp_m_o;
        t0 = bus.cmp_t_o;
        h0 = bus.cmp_h_o;
        stall_bad = 0;
        repeat (12) begin
          @(posedge clk); #1;
          if (bus.data_valid_i !== 1'b1 || bus.data_ready_o !== 1'b0 || bus.cmp_m_o !== m0 ||
              bus.cmp_t_o !== t0 || bus.cmp_h_o !== h0) stall_bad++;
        end
        chk("stall cycles with word taken or outputs moving", 512'(stall_bad), 512'(0));
      end
    join
    core_lat = -1;
    spur_en  = 1'b1;

    // Reset in the middle of a message, then a clean "abc".
    fill_msg(100, 0);
    bus.cfg_nn_i = 7'd64;
    send_msg(5, ok);
    chk("partial msg handshake", 512'(ok), 512'(1));
    #2 nreset = 1'b0;
    #1;
    check_reset_state("mid reset");
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("ready after mid reset", 512'(bus.data_ready_o), 512'(1));
    run_msg("abc after reset", 3, 1, 1, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
